// File: rtl/ttl_pkg.sv
// rtl/ttl_pkg.sv - shared constants, types and helpers for the TTL logic library models
package ttl_pkg;

    localparam logic TTL_LOW  = 1'b0;
    localparam logic TTL_HIGH = 1'b1;

    typedef logic [7:0] ttl_byte_t;

    // Number of bits needed to encode values 0..value-1; used to size counters
    // that must hold the value WIDTH itself (call with WIDTH+1).
    function automatic int ttl_clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ls165_piso.sv
// rtl/ls165_piso.sv - SN74LS165-style parallel-in/serial-out shift register, MSB first
//
// Ports:
//   _CLK      rising-edge clock
//   _CLR      synchronous active-high reset, highest priority
//   _SH_LD    active-low load: 0 loads _D, 1 shifts
//   _CLK_INH  active-high inhibit: holds the register while shifting
//   _SER      serial input entering bit 0 on each shift
//   _D        parallel data, _D[WIDTH-1] is the first bit out
//   _QH       serial output (register MSB)
//   _QH_N     complement of _QH
//   _EMPTY    only with LS165_BITCNT_EN: high once WIDTH bits have been shifted
//
// Optional feature macro: LS165_BITCNT_EN
module ls165_piso
    import ttl_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             _CLK,
    input  logic             _CLR,
    input  logic             _SH_LD,
    input  logic             _CLK_INH,
    input  logic             _SER,
    input  logic [WIDTH-1:0] _D,
    output logic             _QH,
    output logic             _QH_N
`ifdef LS165_BITCNT_EN
    ,
    output logic             _EMPTY
`endif
);

    logic [WIDTH-1:0] q;

    // The real part loads asynchronously; here load is an ordinary synchronous
    // priority above inhibit, so a held load makes q track _D every edge.
    always_ff @(posedge _CLK) begin
        if (_CLR) begin
            q <= RST_VAL;
        end else if (_SH_LD == TTL_LOW) begin
            q <= _D;
        end else if (_CLK_INH == TTL_HIGH) begin
            q <= q;
        end else begin
            q <= {q[WIDTH-2:0], _SER};
        end
    end

    assign _QH   = q[WIDTH-1];
    assign _QH_N = ~q[WIDTH-1];

`ifdef LS165_BITCNT_EN
    localparam int             CNT_W    = ttl_clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [CNT_W-1:0] cnt;

    // Counts bits shifted out since the last load; reset reports empty since
    // no loaded word is pending.
    always_ff @(posedge _CLK) begin
        if (_CLR) begin
            cnt <= CNT_FULL;
        end else if (_SH_LD == TTL_LOW) begin
            cnt <= '0;
        end else if (_CLK_INH == TTL_HIGH) begin
            cnt <= cnt;
        end else if (cnt != CNT_FULL) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign _EMPTY = (cnt == CNT_FULL);
`endif

endmodule

// File: tb/tb_ls165_piso.sv
// tb/tb_ls165_piso.sv - directed self-checking bench for ls165_piso (WIDTH=8)
module tb_ls165_piso;

    logic       clk;
    logic       clr;
    logic       sh_ld;
    logic       clk_inh;
    logic       ser;
    logic [7:0] d;
    logic       qh;
    logic       qh_n;
`ifdef LS165_BITCNT_EN
    logic       empty;
`endif

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    ls165_piso #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        ._CLK     (clk),
        ._CLR     (clr),
        ._SH_LD   (sh_ld),
        ._CLK_INH (clk_inh),
        ._SER     (ser),
        ._D       (d),
        ._QH      (qh),
        ._QH_N    (qh_n)
`ifdef LS165_BITCNT_EN
        ,
        ._EMPTY   (empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        total = total + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_empty(input string tag, input logic exp);
`ifdef LS165_BITCNT_EN
        check(tag, empty, exp);
`else
        if (exp === 1'bx) $display("unused %s", tag);
`endif
    endtask

    logic [7:0] word;

    initial begin
        clr = 1'b1; sh_ld = 1'b0; clk_inh = 1'b0; ser = 1'b0; d = 8'hFF;

        // Reset overrides a simultaneous load of all ones
        step();
        check("rst_qh_0", qh, 1'b0);
        check("rst_qhn_0", qh_n, 1'b1);
        step();
        check("rst_qh_1", qh, 1'b0);
        check("rst_qhn_1", qh_n, 1'b1);
        check_empty("rst_empty", 1'b1);

        clr = 1'b0;
        step();
        check("post_rst_load_qh", qh, 1'b1);
        check("post_rst_load_qhn", qh_n, 1'b0);
        check_empty("load_empty", 1'b0);

        // Load A5 and shift out MSB first, zeros follow
        word = 8'hA5;
        d = word; sh_ld = 1'b0;
        step();
        check("a5_load", qh, 1'b1);
        sh_ld = 1'b1; ser = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            step();
            check($sformatf("a5_bit%0d", i), qh, word[i]);
        end
        step();
        check("a5_after8", qh, 1'b0);
        step();
        check("a5_after9", qh, 1'b0);
        check("a5_after9_n", qh_n, 1'b1);

        // Serial fill: ones arrive at QH on the 8th shift
        d = 8'h00; sh_ld = 1'b0;
        step();
        check("fill_load", qh, 1'b0);
        check_empty("fill_load_empty", 1'b0);
        sh_ld = 1'b1; ser = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            check($sformatf("fill_shift%0d", i), qh, 1'b0);
            check_empty($sformatf("fill_empty%0d", i), 1'b0);
        end
        step();
        check("fill_shift8", qh, 1'b1);
        check_empty("fill_empty8", 1'b1);
        step();
        check_empty("fill_empty_sat", 1'b1);

        // Inhibit with 80: shift once, hold 5 edges, release
        d = 8'h80; sh_ld = 1'b0; ser = 1'b0;
        step();
        check("inh80_load", qh, 1'b1);
        sh_ld = 1'b1;
        step();
        check("inh80_shift1", qh, 1'b0);
        clk_inh = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("inh80_hold%0d", i), qh, 1'b0);
        end
        clk_inh = 1'b0;
        step();
        check("inh80_release", qh, 1'b0);

        // Inhibit with alternating bits so a missed hold toggles QH
        d = 8'h55; sh_ld = 1'b0;
        step();
        check("inh55_load", qh, 1'b0);
        sh_ld = 1'b1;
        step();
        check("inh55_shift1", qh, 1'b1);
        clk_inh = 1'b1; ser = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("inh55_hold%0d", i), qh, 1'b1);
            check_empty($sformatf("inh55_empty%0d", i), 1'b0);
        end
        clk_inh = 1'b0; ser = 1'b0;
        step();
        check("inh55_release", qh, 1'b0);

        // Load beats inhibit; confirm the full word 81 was captured
        d = 8'h81; sh_ld = 1'b0; clk_inh = 1'b1;
        step();
        check("prio_load_qh", qh, 1'b1);
        check("prio_load_qhn", qh_n, 1'b0);
        sh_ld = 1'b1; clk_inh = 1'b0; ser = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            check($sformatf("prio81_shift%0d", i), qh, 1'b0);
        end
        step();
        check("prio81_shift7", qh, 1'b1);

        // Reset beats load; q must be all zeros afterwards
        d = 8'hFF; sh_ld = 1'b0; clr = 1'b1;
        step();
        check("prio_clr_qh", qh, 1'b0);
        clr = 1'b0; sh_ld = 1'b1; ser = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            check($sformatf("prio_clr_shift%0d", i), qh, 1'b0);
        end

        // Reset mid-word discards the remaining ones
        d = 8'hFF; sh_ld = 1'b0;
        step();
        check("mid_load", qh, 1'b1);
        sh_ld = 1'b1; ser = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("mid_shift%0d", i), qh, 1'b1);
        end
        clr = 1'b1;
        step();
        check("mid_clr", qh, 1'b0);
        check_empty("mid_clr_empty", 1'b1);
        clr = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("mid_post%0d", i), qh, 1'b0);
        end

        // Continuous load tracks D each edge
        sh_ld = 1'b0; ser = 1'b1;
        d = 8'h80; step(); check("track_80", qh, 1'b1);
        d = 8'h7F; step(); check("track_7f", qh, 1'b0);
        d = 8'hC0; step(); check("track_c0", qh, 1'b1);
        d = 8'h00; step(); check("track_00", qh, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
